// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_BYPASS_EN: back-to-back grants from HOLD for 1 op/cycle.
`timescale 1ns/1ps
module alu_share_arb #(
  parameter int unsigned      OP_W   = 5,
  parameter int unsigned      D_W    = 8,
  parameter logic [OP_W-1:0]  OP_BLT = 5'd5,
  parameter logic [OP_W-1:0]  OP_BEQ = 5'd6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_op,
  input  logic [2*D_W-1:0]  req_a,
  input  logic [2*D_W-1:0]  req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [D_W-1:0]    rsp_data,
  output logic [1:0]        flag_eq,
  output logic [1:0]        flag_lt,
  output logic [OP_W-1:0]   alu_op,
  output logic [D_W-1:0]    alu_a,
  output logic [D_W-1:0]    alu_b,
  input  logic [D_W-1:0]    alu_out,
  input  logic              alu_eq,
  input  logic              alu_lt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]      r_state;
  logic            r_rr_last;
  logic            r_owner;
  logic [1:0]      r_rsp_valid;
  logic [D_W-1:0]  r_rsp_data;
  logic [OP_W-1:0] r_op;
  logic [D_W-1:0]  r_a;
  logic [D_W-1:0]  r_b;
  logic [1:0]      r_flag_eq;
  logic [1:0]      r_flag_lt;

  logic            w_win;
  logic [1:0]      w_win_vec;
  logic            w_can_arb;
  logic            w_grant;
  logic [OP_W-1:0] w_win_op;
  logic [D_W-1:0]  w_win_a;
  logic [D_W-1:0]  w_win_b;

  always_comb begin
    // On a tie the requester that did not win last time goes next
    w_win     = (req_valid == 2'b11) ? ~r_rr_last : req_valid[1];
    w_win_vec = {w_win, ~w_win};
    w_win_op  = w_win ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
    w_win_a   = w_win ? req_a[2*D_W-1:D_W]    : req_a[D_W-1:0];
    w_win_b   = w_win ? req_b[2*D_W-1:D_W]    : req_b[D_W-1:0];
`ifdef ALU_ARB_BYPASS_EN
    w_can_arb = (r_state == S_IDLE) || rsp_ready[r_owner];
`else
    w_can_arb = (r_state == S_IDLE);
`endif
    w_grant   = w_can_arb && (|req_valid);
  end

  always_comb begin
    req_ready = '0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    if (w_grant) begin
      req_ready = w_win_vec;
      alu_op    = w_win_op;
      alu_a     = w_win_a;
      alu_b     = w_win_b;
    end else if (r_state == S_HOLD) begin
      alu_op = r_op;
      alu_a  = r_a;
      alu_b  = r_b;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b1;
      r_owner     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_flag_eq   <= '0;
      r_flag_lt   <= '0;
    end else if (w_grant) begin
      r_state     <= S_HOLD;
      r_owner     <= w_win;
      r_rr_last   <= w_win;
      r_rsp_valid <= w_win_vec;
      r_rsp_data  <= alu_out;
      r_op        <= w_win_op;
      r_a         <= w_win_a;
      r_b         <= w_win_b;
      // The ALU drives EQ/LT meaningfully only for its compare ops
      if (w_win_op == OP_BLT) r_flag_lt[w_win] <= alu_lt;
      if (w_win_op == OP_BEQ) r_flag_eq[w_win] <= alu_eq;
    end else if ((r_state == S_HOLD) && rsp_ready[r_owner]) begin
      r_rsp_valid <= '0;
      r_state     <= S_IDLE;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign flag_eq   = r_flag_eq;
  assign flag_lt   = r_flag_lt;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic
// against a transaction-level reference model. Honours ALU_ARB_BYPASS_EN.
`timescale 1ns/1ps
module tb_alu_share_arb;
  localparam int OP_W = 5;
  localparam int D_W  = 8;
`ifdef ALU_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready, flag_eq, flag_lt;
  logic [2*OP_W-1:0] req_op;
  logic [2*D_W-1:0]  req_a, req_b;
  logic [D_W-1:0]    rsp_data, alu_a, alu_b, alu_out;
  logic [OP_W-1:0]   alu_op;
  logic              alu_eq, alu_lt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_share_arb #(.OP_W(OP_W), .D_W(D_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flag_eq(flag_eq), .flag_lt(flag_lt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_eq(alu_eq), .alu_lt(alu_lt)
  );

  // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 BLT, 6 BEQ; EQ/LT always driven
  function automatic logic [D_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                            input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a - b;
      5'd6:    return a - b;
      default: return ~a;
    endcase
  endfunction

  always_comb begin
    alu_out = alu_fn(alu_op, alu_a, alu_b);
    alu_eq  = (alu_a == alu_b);
    alu_lt  = (alu_a < alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_busy;
  int              m_owner;
  bit              m_last;
  logic [D_W-1:0]  m_data, m_a, m_b;
  logic [OP_W-1:0] m_op;
  logic [1:0]      m_eq, m_lt;

  function automatic logic [OP_W-1:0] op_of(input int i);
    return req_op[i*OP_W +: OP_W];
  endfunction
  function automatic logic [D_W-1:0] a_of(input int i);
    return req_a[i*D_W +: D_W];
  endfunction
  function automatic logic [D_W-1:0] b_of(input int i);
    return req_b[i*D_W +: D_W];
  endfunction

  // Requester granted this cycle, or -1
  function automatic int pick();
    int pref;
    if (m_busy && !(BYP && rsp_ready[m_owner])) return -1;
    if (req_valid == 2'b00) return -1;
    pref = m_last ? 0 : 1;
    return req_valid[pref] ? pref : 1 - pref;
  endfunction

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_busy <= 1'b0; m_owner <= 0; m_last <= 1'b1; m_data <= '0;
      m_op <= '0; m_a <= '0; m_b <= '0; m_eq <= '0; m_lt <= '0;
    end else begin : upd
      int w;
      logic [OP_W-1:0] o;
      logic [D_W-1:0]  a, b;
      w = pick();
      if (w >= 0) begin
        o = op_of(w); a = a_of(w); b = b_of(w);
        m_data <= alu_fn(o, a, b);
        m_busy <= 1'b1; m_owner <= w; m_last <= (w == 1);
        m_op <= o; m_a <= a; m_b <= b;
        if (o == 5'd5) m_lt[w] <= (a < b);
        if (o == 5'd6) m_eq[w] <= (a == b);
      end else if (m_busy && rsp_ready[m_owner]) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (Reset) begin : cmp
      int w;
      logic [1:0]      e_rdy, e_rv;
      logic [OP_W-1:0] e_op;
      logic [D_W-1:0]  e_a, e_b;
      w = pick();
      e_rdy = '0; e_rv = '0; e_op = '0; e_a = '0; e_b = '0;
      if (w >= 0) begin
        e_rdy[w] = 1'b1; e_op = op_of(w); e_a = a_of(w); e_b = b_of(w);
      end else if (m_busy) begin
        e_op = m_op; e_a = m_a; e_b = m_b;
      end
      if (m_busy) e_rv[m_owner] = 1'b1;
      chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("m_rsp_data",  32'(rsp_data),  32'(m_data));
      chk("m_flag_eq",   32'(flag_eq),   32'(m_eq));
      chk("m_flag_lt",   32'(flag_lt),   32'(m_lt));
      chk("m_alu_op",    32'(alu_op),    32'(e_op));
      chk("m_alu_a",     32'(alu_a),     32'(e_a));
      chk("m_alu_b",     32'(alu_b),     32'(e_b));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_req(input int i, input logic [OP_W-1:0] op,
                         input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    req_op[i*OP_W +: OP_W] = op;
    req_a[i*D_W +: D_W]    = a;
    req_b[i*D_W +: D_W]    = b;
    req_valid[i]           = 1'b1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; #2; Reset = 1'b1;
  endtask

  // Raise a request, wait (bounded) for its grant, drop valid after the grant edge
  task automatic issue(input int i, input logic [OP_W-1:0] op,
                       input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    bit got = 1'b0;
    set_req(i, op, a, b);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CLK);
      if (req_ready[i]) got = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL grant_timeout: requester %0d not granted, got ready %b expected bit set", i, req_ready);
    end
    tick();
    req_valid[i] = 1'b0;
  endtask

  logic [1:0] exp_cont [8];
  logic [1:0] gr;

  initial begin
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_flag_eq",   32'(flag_eq),   32'h0);
    chk("rst_flag_lt",   32'(flag_lt),   32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;

    // Single ADD
    tick();
    rsp_ready = 2'b11;
    set_req(0, 5'd0, 8'h0F, 8'h01);
    @(negedge CLK);
    chk("add_ready",  32'(req_ready), 32'h1);
    chk("add_alu_a",  32'(alu_a),     32'h0F);
    tick(); req_valid = '0;
    @(negedge CLK);
    chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("add_rsp_data",  32'(rsp_data),  32'h10);
    tick();
    @(negedge CLK);
    chk("add_idle_valid", 32'(rsp_valid), 32'h0);
    chk("add_idle_aluop", 32'(alu_op),    32'h0);

    // Contention from a fresh reset
    tick(); do_reset();
`ifdef ALU_ARB_BYPASS_EN
    exp_cont = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_cont = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
    set_req(0, 5'd0, 8'h01, 8'h01);
    set_req(1, 5'd0, 8'h02, 8'h02);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk($sformatf("cont_grant%0d", k), 32'(req_ready), 32'(exp_cont[k]));
      chk($sformatf("cont_not_both%0d", k), 32'(rsp_valid == 2'b11), 32'h0);
      tick();
    end
    req_valid = '0;
    tick(); tick();

    // Flag isolation
    issue(1, 5'd5, 8'd3, 8'd7);
    tick();
    @(negedge CLK);
    chk("flag_lt_blt", 32'(flag_lt), 32'h2);
    tick();
    issue(0, 5'd0, 8'd4, 8'd4);
    tick();
    @(negedge CLK);
    chk("flag_lt_add", 32'(flag_lt), 32'h2);
    chk("flag_eq_add", 32'(flag_eq), 32'h0);
    tick();
    issue(0, 5'd6, 8'd5, 8'd5);
    tick();
    @(negedge CLK);
    chk("flag_eq_beq", 32'(flag_eq), 32'h1);
    chk("flag_lt_beq", 32'(flag_lt), 32'h2);

    // Backpressure
    tick();
    rsp_ready = 2'b00;
    set_req(0, 5'd1, 8'h05, 8'h07);
    @(negedge CLK);
    chk("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 5'd0, 8'h01, 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("bp_data%0d", k),  32'(rsp_data),  32'hFE);
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge CLK);
`ifdef ALU_ARB_BYPASS_EN
    chk("bp_release_bypass", 32'(req_ready), 32'h2);
    tick();
`else
    chk("bp_release_hold", 32'(req_ready), 32'h0);
    tick();
    @(negedge CLK);
    chk("bp_grant1", 32'(req_ready), 32'h2);
    tick();
`endif
    req_valid = '0;
    rsp_ready = 2'b11;
    tick();

    // Async reset while holding a result
    rsp_ready = 2'b00;
    set_req(0, 5'd0, 8'h09, 8'h01);
    tick();
    req_valid = '0;
    @(negedge CLK);
    chk("ar_pre_valid", 32'(rsp_valid), 32'h1);
    chk("ar_pre_flags", 32'({flag_eq, flag_lt}), 32'h6);
    #2 Reset = 1'b0;
    #1;
    chk("ar_valid", 32'(rsp_valid), 32'h0);
    chk("ar_data",  32'(rsp_data),  32'h0);
    chk("ar_eq",    32'(flag_eq),   32'h0);
    chk("ar_lt",    32'(flag_lt),   32'h0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, 5'd0, 8'h01, 8'h01);
    set_req(1, 5'd0, 8'h02, 8'h02);
    @(negedge CLK);
    chk("ar_tie_req0", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; tick(); tick();

`ifdef ALU_ARB_BYPASS_EN
    do_reset();
    set_req(0, 5'd0, 8'h10, 8'h0E);
    set_req(1, 5'd1, 8'h40, 8'h02);
    @(negedge CLK);
    chk("byp_g0", 32'(req_ready), 32'h1);
    tick();
    @(negedge CLK);
    chk("byp_g1", 32'(req_ready), 32'h2);
    chk("byp_d0", 32'(rsp_data),  32'h1E);
    tick();
    @(negedge CLK);
    chk("byp_g2", 32'(req_ready), 32'h1);
    chk("byp_d1", 32'(rsp_data),  32'h3E);
    tick();
    req_valid = '0;
    tick(); tick();
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      gr = req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (gr[i] || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 5'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    req_valid = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the core datapath, requester 1 is the self-test/LUT engine.
- Muxes OP/InputA/InputB to the ALU and captures Out into a result register.
- Keeps per-requester EQ/LT flag copies, since the ALU drives EQ/LT only on compare ops.
- Uses a valid/ready handshake on both the request and response sides, with round-robin arbitration.

Parameters:
- OP_W, 5, ALU opcode width.
- D_W, 8, data width.
- OP_BLT, 5'd5, opcode that updates the LT flag.
- OP_BEQ, 5'd6, opcode that updates the EQ flag.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle, bit i.
- req_op  in  2*OP_W  opcodes; requester i uses bits [i*OP_W +: OP_W].
- req_a  in  2*D_W  operand A per requester.
- req_b  in  2*D_W  operand B per requester.
- rsp_valid  out  2  result available for requester i.
- rsp_ready  in  2  requester i consumes its result.
- rsp_data  out  D_W  registered ALU result.
- flag_eq  out  2  EQ flag copy per requester.
- flag_lt  out  2  LT flag copy per requester.
- alu_op  out  OP_W  to ALU OP.
- alu_a  out  D_W  to ALU InputA.
- alu_b  out  D_W  to ALU InputB.
- alu_out  in  D_W  from ALU Out.
- alu_eq  in  1  from ALU EQ.
- alu_lt  in  1  from ALU LT.

Behaviour:
- Reset state (Reset=0, async): state=IDLE, rr_last=1 (requester 0 wins the first tie).
- Outputs after reset: rsp_valid=0, rsp_data=0, flag_eq=0, flag_lt=0, req_ready=0.
- Outputs in IDLE: alu_op/alu_a/alu_b=0.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Winner: if exactly one req_valid is set, that requester wins. If both are set, the requester not equal to rr_last wins.
  - Grant: req_ready[winner]=1 combinationally in the same cycle. alu_* are driven from the winner's inputs.
  - At the clock edge: rsp_data<=alu_out, owner<=winner, rr_last<=winner, rsp_valid[winner]<=1, state<=HOLD.
  - If no request is valid: alu_*=0 and req_ready=0.
- Latency: request accepted in cycle N, rsp_valid asserted in cycle N+1.
- Flags update only on an accepted request:
  - If op==OP_BLT, flag_lt[winner]<=alu_lt.
  - If op==OP_BEQ, flag_eq[winner]<=alu_eq.
  - Other ops leave both flag copies unchanged. The other requester's flags are never touched.
- HOLD:
  - req_ready=0 and alu_* are driven from the owner's last inputs.
  - rsp_data and rsp_valid[owner] are held stable until rsp_ready[owner]=1.
  - On that edge, rsp_valid is cleared and state<=IDLE.
- Throughput: one operation per 2 cycles minimum.
  - rsp_ready of the non-owner is ignored.
  - A request arriving during HOLD waits; req_valid must stay high until req_ready.
- Simultaneous events:
  - A requester may deassert req_valid before grant without penalty.
  - A rsp handshake and a new request in the same cycle: the new request is not granted until the next cycle, in IDLE.
- Reset mid-operation: any held result is discarded, flags clear, and state returns to IDLE.
- Width rule: the result is D_W bits, truncated exactly as the ALU produces it; there is no carry output.

Optional Feature:
- Macro: ALU_ARB_BYPASS_EN.
- Defined:
  - In HOLD, if rsp_ready[owner]=1 and any req_valid is set in the same cycle, arbitration runs combinationally and the grant and capture happen on that edge.
  - The state remains HOLD with the new owner, giving 1 op/cycle sustained throughput.
  - Round-robin rules are unchanged. The winner uses rr_last, which is updated by the previous grant.
- Undefined: behaviour is exactly as above, with a minimum of 2 cycles per operation.

Test Plan:
- Single request, ADD: Reset release, then req0 op=ADD a=8'h0F b=8'h01 with rsp_ready held 1.
  - Expect req_ready=2'b01 in cycle N.
  - Expect rsp_valid=2'b01 and rsp_data=8'h10 in cycle N+1, and IDLE in N+2.
- Contention: both requesters valid continuously, each with rsp_ready=1.
  - Expect grants 0,1,0,1, one grant every 2 cycles.
  - Expect rsp_valid to alternate and never be 2'b11.
- Flag isolation:
  - req1 op=OP_BLT a=3 b=7 gives alu_lt=1, so flag_lt=2'b10.
  - Then req0 op=ADD leaves flag_lt=2'b10.
  - Then req0 op=OP_BEQ a=b=5 gives flag_eq=2'b01.
- Backpressure: req0 SUB a=8'h05 b=8'h07 with rsp_ready=0 for 4 cycles, while req1 stays valid.
  - Expect rsp_data=8'hFE held with rsp_valid=2'b01 and req_ready=0 throughout.
  - After rsp_ready=1, expect req1 granted the next cycle.
- Async reset in HOLD: assert Reset=0 mid-clock while rsp_valid=1 and flags are set.
  - Expect rsp_valid=0, rsp_data=0 and flags=0 immediately, with no clock edge needed.
  - Expect the first grant after release to go to req0 on a tie.
- With ALU_ARB_BYPASS_EN: both requesters valid and rsp_ready=2'b11.
  - Expect one grant per cycle alternating 0,1,0.
  - Expect rsp_data to update every cycle with correct results.
